// File: rtl/csa_pkg.sv
// Shared constants and helpers for the three-operand carry-save adder.
// CSA_PIPE_EN selects the two-stage build (CSA registered ahead of the resolve).
package csa_pkg;

  localparam int CSA_W_DEFAULT = 4;

`ifdef CSA_PIPE_EN
  localparam int CSA_LAT = 2;
`else
  localparam int CSA_LAT = 1;
`endif

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// W-bit ripple-carry adder built from a generate chain of full adders.
module ripple_carry_adder
  import csa_pkg::*;
#(
  parameter int W = CSA_W_DEFAULT
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Each stage owns its carry so the chain stays a plain wire path, not one self-feeding vector.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic ci, co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    assign s[i] = x[i] ^ y[i] ^ ci;
    assign co   = maj3(x[i], y[i], ci);
  end

  assign cout = g_fa[W-1].co;

endmodule

// File: rtl/csa3_sum_pipe.sv
// Pipelined a+b+c: 3:2 carry-save reduction then ripple resolve into a W+2-bit sum.
// Define CSA_PIPE_EN to register the CSA vectors (latency 2); otherwise latency is 1.
module csa3_sum_pipe
  import csa_pkg::*;
#(
  parameter int W = CSA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] csa_s,
  output logic [W-1:0] csa_co,
  output logic         out_valid,
  output logic [W+1:0] sum
);

  for (genvar i = 0; i < W; i++) begin : g_csa
    assign csa_s[i]  = a[i] ^ b[i] ^ c[i];
    assign csa_co[i] = maj3(a[i], b[i], c[i]);
  end

  logic [CSA_LAT:1] vld_pipe;
  logic [W-1:0]     r_s, r_co;
  logic             rca_vld;
  logic [W-1:0]     rca_s;
  logic             rca_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= (vld_pipe << 1) | CSA_LAT'(in_valid);
  end

`ifdef CSA_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s  <= '0;
      r_co <= '0;
    end else begin
      r_s  <= csa_s;
      r_co <= csa_co;
    end
  end
  assign rca_vld = vld_pipe[1];
`else
  assign r_s     = csa_s;
  assign r_co    = csa_co;
  assign rca_vld = in_valid;
`endif

  // Bit 0 of the partial sum has nothing to add, so the adder only sees bits W-1:1.
  ripple_carry_adder #(.W(W)) u_rca (
    .x    ({1'b0, r_s[W-1:1]}),
    .y    (r_co),
    .cin  (1'b0),
    .s    (rca_s),
    .cout (rca_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sum <= '0;
    else if (rca_vld) sum <= {rca_co, rca_s, r_s[0]};
  end

  assign out_valid = vld_pipe[CSA_LAT];

endmodule

// File: tb/tb_csa3_sum_pipe.sv
// Self-checking bench for csa3_sum_pipe at W=4: vector table, valid gaps,
// async reset mid-stream, exhaustive and random streams against an arithmetic model.
module tb_csa3_sum_pipe;

`ifdef CSA_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b, c;
  logic [3:0] csa_s, csa_co;
  logic       out_valid;
  logic [5:0] sum;

  csa3_sum_pipe #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .csa_s(csa_s), .csa_co(csa_co),
    .out_valid(out_valid), .sum(sum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { bit v; int s; } ent_t;
  ent_t q[$];
  int   model_sum = 0;

  typedef struct {
    logic [3:0] a, b, c;
    logic [3:0] exp_s, exp_co;
    int         exp_sum;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Column-wise bit counting: the count's low bit stays, the high bit moves up one weight.
  task automatic ref_csa(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                         output logic [3:0] es, output logic [3:0] eco);
    for (int i = 0; i < 4; i++) begin
      int n;
      n = int'(ta[i]) + int'(tb_[i]) + int'(tc[i]);
      es[i]  = (n % 2) == 1;
      eco[i] = n >= 2;
    end
  endtask

  // Called from edge+1: drive, check combinational CSA, clock, check registered outputs.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                      input logic tv);
    logic [3:0] es, eco;
    ent_t e;
    bit   exp_v;
    a = ta; b = tb_; c = tc; in_valid = tv;
    #1;
    ref_csa(ta, tb_, tc, es, eco);
    chk("csa_s", int'(csa_s), int'(es));
    chk("csa_co", int'(csa_co), int'(eco));
    @(posedge clk); #1;
    q.push_back('{v: tv, s: int'(ta) + int'(tb_) + int'(tc)});
    exp_v = 1'b0;
    if (q.size() == LAT) begin
      e = q.pop_front();
      exp_v = e.v;
      if (e.v) model_sum = e.s;
    end
    chk("out_valid", int'(out_valid), int'(exp_v));
    chk("sum", int'(sum), model_sum);
  endtask

  vec_t tab[6];
  int   ov[5];
  int   sm[5];

  initial begin
    tab[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0};
    tab[1] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 45};
    tab[2] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 3};
    tab[3] = '{4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 8};
    tab[4] = '{4'h5, 4'h6, 4'h7, 4'h4, 4'h7, 18};
    tab[5] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 27};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    #12;
    chk("reset_sum", int'(sum), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Vector table: each entry followed by idle cycles so sum settles and holds.
    foreach (tab[i]) begin
      step(tab[i].a, tab[i].b, tab[i].c, 1'b1);
      chk("tab_csa_s", int'(csa_s), int'(tab[i].exp_s));
      chk("tab_csa_co", int'(csa_co), int'(tab[i].exp_co));
      repeat (LAT - 1) step(4'h0, 4'h0, 4'h0, 1'b0);
      chk("tab_sum", int'(sum), tab[i].exp_sum);
      step(4'h3, 4'h3, 4'h3, 1'b0);
      chk("tab_hold", int'(sum), tab[i].exp_sum);
    end

    // Valid pattern 1,0,1 then drain.
    step(4'h5, 4'h6, 4'h7, 1'b1); ov[0] = out_valid; sm[0] = sum;
    step(4'hA, 4'hB, 4'hC, 1'b0); ov[1] = out_valid; sm[1] = sum;
    step(4'h9, 4'h9, 4'h9, 1'b1); ov[2] = out_valid; sm[2] = sum;
    step(4'h0, 4'h0, 4'h0, 1'b0); ov[3] = out_valid; sm[3] = sum;
    step(4'h0, 4'h0, 4'h0, 1'b0); ov[4] = out_valid; sm[4] = sum;
    chk("gap_v0", ov[LAT-1], 1); chk("gap_s0", sm[LAT-1], 18);
    chk("gap_v1", ov[LAT], 0);   chk("gap_s1", sm[LAT], 18);
    chk("gap_v2", ov[LAT+1], 1); chk("gap_s2", sm[LAT+1], 27);

    // Async reset between edges with results in flight.
    step(4'h3, 4'h4, 4'h5, 1'b1);
    step(4'h7, 4'h7, 4'h7, 1'b1);
    a = 4'hE; b = 4'hD; c = 4'hC; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sum", int'(sum), 0);
    chk("async_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("rst_held_sum", int'(sum), 0);
    chk("rst_held_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    q.delete();
    model_sum = 0;
    repeat (3) step(4'h1, 4'h2, 4'h3, 1'b0);
    step(4'h2, 4'h2, 4'h2, 1'b1);
    repeat (LAT) step(4'h0, 4'h0, 4'h0, 1'b0);
    chk("post_rst_sum", int'(sum), 6);

    // Exhaustive back-to-back stream.
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] v;
      v = 12'(i);
      step(v[11:8], v[7:4], v[3:0], 1'b1);
    end

    // Random stream with random valid gaps.
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    repeat (LAT) step(4'h0, 4'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csa3_sum_pipe.md
# csa3_sum_pipe

Pipelined three-operand adder. A bit-parallel carry-save (3:2) stage reduces operands a, b and c to a partial-sum vector and a carry vector. A ripple-carry stage resolves those vectors into the exact W+2-bit sum. It is the operand-reduction building block for multi-input accumulation, for example neighbour counting in the life-grid datapath.

## Interface
Parameters:
- W, default 4: operand width, legal range W ≥ 2.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- in_valid, in, 1: a, b and c are valid this cycle.
- a, in, W: operand A, unsigned.
- b, in, W: operand B, unsigned.
- c, in, W: operand C, unsigned.
- csa_s, out, W: combinational partial sum, bit i = a[i]^b[i]^c[i], weight 2^i.
- csa_co, out, W: combinational carry, bit i = majority(a[i],b[i],c[i]), weight 2^(i+1).
- out_valid, out, 1: sum is valid this cycle.
- sum, out, W+2: registered a+b+c, exact with no overflow.

## Operation
- CSA stage: purely combinational, with no carry propagation between bit positions.
- Resolve stage: the ripple_carry_adder sub-module is W bits wide and takes cin=0.
  - Operand x = {1'b0, csa_s[W-1:1]}; operand y = csa_co.
  - sum[0] = csa_s[0].
  - sum[W:1] = rca sum.
  - sum[W+1] = rca carry-out.
- Arithmetic: unsigned. The maximum result is 3·(2^W−1), which always fits in W+2 bits.
- Control: no backpressure. Every in_valid=1 cycle produces exactly one out_valid=1 cycle, in order.
- Result hold: when in_valid=0, the pipeline still advances. sum holds its last value and out_valid deasserts.
- csa_s and csa_co track the inputs combinationally and have no reset value.

## Timing
- Reset state (rst_n low): sum=0, out_valid=0, and all internal pipeline registers are 0, effective immediately with no clock needed.
- Reset mid-operation: all in-flight results are discarded. The first out_valid after rst_n rises belongs to an input captured after deassertion.
- Latency: 2 cycles with CSA_PIPE_EN defined, 1 cycle without it.
- Throughput: one result per cycle.
- Back-to-back valid inputs produce back-to-back valid outputs with no bubbles.
- Critical path: the W-bit ripple chain plus one XOR. A single stage must meet timing for W up to 16.

## Configuration
- CSA_PIPE_EN defined:
  - csa_s and csa_co are registered together with in_valid (stage 1).
  - The ripple-carry resolve is then registered into sum and out_valid (stage 2).
  - Latency is 2.
- CSA_PIPE_EN undefined:
  - The CSA and ripple-carry logic form one combinational path into the sum and out_valid registers.
  - Latency is 1.
- The csa_s and csa_co ports are combinational in both builds.

## Structure
- Shared package csa_pkg:
  - CSA_W_DEFAULT = 4.
  - CSA_LAT constant (2 or 1, selected by the same macro).
  - Helper function maj3 for the majority bit.
- Sub-module ripple_carry_adder, parameter W:
  - Inputs: x[W-1:0], y[W-1:0], cin.
  - Outputs: s[W-1:0], cout.
  - Built from a generate chain of full adders.
- Top level: CSA stage, optional stage-1 registers, one ripple_carry_adder instance, output registers and the valid pipeline.

## Test plan
Use W=4 and compare against a reference model at the configured latency for all scenarios.
- Exhaustive: drive all 4096 {a,b,c} combinations back-to-back with in_valid=1 → every sum equals a+b+c after CSA_LAT cycles. out_valid stays high continuously.
- Zero/max: a=b=c=0 → sum=6'd0. a=b=c=4'hF → csa_s=4'hF, csa_co=4'hF, sum=6'd45.
- Single bit: a=b=c=4'h1 → csa_s=4'h1, csa_co=4'h1, sum=6'd3. a=4'h8, b=0, c=0 → sum=6'd8.
- Valid gaps: pulse in_valid in the pattern 1,0,1 with values 5+6+7 and 9+9+9 → out_valid is 1,0,1 at latency, sum is 18 then 27, and sum holds 18 during the gap.
- Async reset mid-stream: assert rst_n=0 between clock edges with results in flight → sum=0 and out_valid=0 immediately. After release, no stale out_valid appears.
- Build both with and without CSA_PIPE_EN → latency is 2 and 1 respectively, with identical result sequences.
